// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM bank arbiter: FSM states, read tags and id sizing.
package bram_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } state_t;

  // Tag ids are stored at a fixed width so the struct is usable for any NUM_REQ up to 256.
  localparam int unsigned MaxIdW = 8;

  typedef struct packed {
    logic              valid;
    logic [MaxIdW-1:0] id;
  } tag_t;

  function automatic int unsigned id_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above prio_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdW    = 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    prio_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdW-1:0]    grant_id_o,
  output logic              valid_o
);

  int unsigned cand;

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    valid_o    = 1'b0;
    cand       = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = (32'(prio_i) + k) % NumReq;
      // Constant-index match avoids a variable bit-select into req_i.
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (!valid_o && (i == cand) && req_i[i]) begin
          valid_o    = 1'b1;
          grant_o[i] = 1'b1;
          grant_id_o = IdW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/bram_bank_arbiter.sv
// Round-robin arbiter sharing one wide BRAM port among NUM_REQ requesters, with burst locking
// and read-data routing back to the issuing requester after the BRAM read latency.
module bram_bank_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned WE_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*WE_WIDTH-1:0]      req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wrdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rddata,
  output logic                             en_o,
  output logic [WE_WIDTH-1:0]              we_o,
  output logic [ADDR_WIDTH-1:0]            addr_o,
  output logic [DATA_WIDTH-1:0]            wrdata_o,
  input  logic [DATA_WIDTH-1:0]            rddata_i
);

  localparam int unsigned IdW = id_w(NUM_REQ);

  function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
    return (id == IdW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  state_t                  state_q, state_d;
  logic [IdW-1:0]          owner_q, owner_d;
  logic [IdW-1:0]          prio_q, prio_d;

  logic [NUM_REQ-1:0]      arb_grant;
  logic [IdW-1:0]          arb_id;
  logic                    arb_valid;

  logic [NUM_REQ-1:0]      owner_oh;
  logic [IdW-1:0]          sel_id;
  logic                    sel_last;
  logic [WE_WIDTH-1:0]     sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wrdata;
  logic                    accept;

  logic                    en_q;
  logic [WE_WIDTH-1:0]     we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wrdata_q;

  tag_t                    port_tag_d, port_tag_q;
  tag_t                    tag_q [READ_LATENCY];
  tag_t                    tag_out;

  rr_arbiter #(
    .NumReq (NUM_REQ),
    .IdW    (IdW)
  ) u_rr_arbiter (
    .req_i      (req_valid),
    .prio_i     (prio_q),
    .grant_o    (arb_grant),
    .grant_id_o (arb_id),
    .valid_o    (arb_valid)
  );

  always_comb begin
    owner_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      owner_oh[i] = (owner_q == IdW'(i));
    end
  end

  // Ready is forced low while reset is held so nothing is accepted during reset.
  always_comb begin
    req_ready = '0;
    if (rstn) begin
      req_ready = (state_q == StLocked) ? owner_oh : arb_grant;
    end
    sel_id = (state_q == StLocked) ? owner_q : arb_id;
    accept = |(req_valid & req_ready);
  end

  always_comb begin
    sel_last   = 1'b0;
    sel_we     = '0;
    sel_addr   = '0;
    sel_wrdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_id == IdW'(i)) begin
        sel_last   = req_last[i];
        sel_we     = req_we[i*WE_WIDTH +: WE_WIDTH];
        sel_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wrdata = req_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (sel_last) begin
            prio_d = next_id(arb_id);
          end else begin
            state_d = StLocked;
            owner_d = arb_id;
          end
        end
      end
      StLocked: begin
        // A cycle without the owner's valid is a bubble; the lock is kept.
        if (accept && sel_last) begin
          state_d = StIdle;
          prio_d  = next_id(owner_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    port_tag_d       = '0;
    port_tag_d.valid = accept && (sel_we == '0);
    port_tag_d.id    = MaxIdW'(sel_id);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      prio_q     <= '0;
      en_q       <= 1'b0;
      we_q       <= '0;
      addr_q     <= '0;
      wrdata_q   <= '0;
      port_tag_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      prio_q     <= prio_d;
      en_q       <= accept;
      we_q       <= accept ? sel_we : '0;
      if (accept) begin
        addr_q   <= sel_addr;
        wrdata_q <= sel_wrdata;
      end
      // The tag rides with the beat on the port, then ages READ_LATENCY cycles to meet rddata_i.
      port_tag_q <= port_tag_d;
      tag_q[0]   <= port_tag_q;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    tag_out   = tag_q[READ_LATENCY-1];
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_out.valid && (tag_out.id == MaxIdW'(i));
    end
  end

  assign rsp_rddata = rddata_i;
  assign en_o       = en_q;
  assign we_o       = we_q;
  assign addr_o     = addr_q;
  assign wrdata_o   = wrdata_q;

endmodule

// File: tb/tb_bram_bank_arbiter.sv
// Scoreboard bench for bram_bank_arbiter: stimulus queues expected grants, monitors check
// grant order, BRAM-port beats and routed read responses with exact cycle timing.
module tb_bram_bank_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int WW = 4;
  localparam int RL = 2;

  localparam logic [DW-1:0] M005 = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] M007 = 32'hAABB_CCDD;
  localparam logic [DW-1:0] M010 = 32'h1111_0010;
  localparam logic [DW-1:0] M020 = 32'h2222_0020;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NR-1:0]     req_valid, req_ready, req_last, rsp_valid;
  logic [NR*WW-1:0]  req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wrdata;
  logic [DW-1:0]     rsp_rddata;
  logic              en_o;
  logic [WW-1:0]     we_o;
  logic [AW-1:0]     addr_o;
  logic [DW-1:0]     wrdata_o;
  logic [DW-1:0]     rddata_i;

  logic              v  [NR];
  logic              l  [NR];
  logic [WW-1:0]     we [NR];
  logic [AW-1:0]     ad [NR];
  logic [DW-1:0]     wd [NR];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int            id;
    logic [WW-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
  } txn_t;

  typedef struct {
    int   cyc;
    txn_t t;
  } tim_t;

  txn_t acc_q[$];
  tim_t port_q[$];
  tim_t rsp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_valid  = '0;
    req_last   = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wrdata = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]            = v[i];
      req_last[i]             = l[i];
      req_we[i*WW +: WW]      = we[i];
      req_addr[i*AW +: AW]    = ad[i];
      req_wrdata[i*DW +: DW]  = wd[i];
    end
  end

  bram_bank_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .WE_WIDTH     (WW),
    .READ_LATENCY (RL)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_last   (req_last),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wrdata (req_wrdata),
    .rsp_valid  (rsp_valid),
    .rsp_rddata (rsp_rddata),
    .en_o       (en_o),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .wrdata_o   (wrdata_o),
    .rddata_i   (rddata_i)
  );

  // BRAM model: preset contents overlaid by writes, READ_LATENCY register stages on reads.
  logic [DW-1:0] mem     [4096];
  bit            written [4096];
  logic [DW-1:0] rd_pipe [RL];

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    case (a)
      12'h005: return M005;
      12'h007: return M007;
      12'h010: return M010;
      12'h020: return M020;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
    return written[a] ? mem[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [WW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < WW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (en_o) begin
      if (we_o != '0) begin
        mem[addr_o]     <= merge(rd_word(addr_o), wrdata_o, we_o);
        written[addr_o] <= 1'b1;
      end else begin
        rd_pipe[0] <= rd_word(addr_o);
      end
    end
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign rddata_i = rd_pipe[RL-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic txn_t mk(input int id, input logic [WW-1:0] w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [DW-1:0] r);
    txn_t t;
    t.id = id; t.we = w; t.addr = a; t.wd = d; t.rd = r;
    return t;
  endfunction

  // Grant monitor: at most one accept per cycle, in the order the stimulus predicted.
  always @(negedge clk) begin
    int   n;
    int   id;
    txn_t t;
    if (rstn === 1'b1) begin
      n  = 0;
      id = -1;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          n++;
          id = i;
        end
      end
      chk("one_grant_max", 64'(n <= 1), 64'd1);
      if (n >= 1) begin
        chk("grant_expected", 64'(acc_q.size() > 0), 64'd1);
        if (acc_q.size() > 0) begin
          t = acc_q.pop_front();
          chk("grant_id", 64'(id), 64'(t.id));
          port_q.push_back('{cyc: cyc + 1, t: t});
          if (t.we == '0) rsp_q.push_back('{cyc: cyc + 1 + RL, t: t});
        end
      end
    end
  end

  // Port monitor: each beat one cycle after acceptance, otherwise en_o and we_o low.
  always @(negedge clk) begin
    tim_t e;
    if (port_q.size() > 0 && port_q[0].cyc == cyc) begin
      e = port_q.pop_front();
      chk("port_en", 64'(en_o), 64'd1);
      chk("port_we", 64'(we_o), 64'(e.t.we));
      chk("port_addr", 64'(addr_o), 64'(e.t.addr));
      if (e.t.we != '0) chk("port_wrdata", 64'(wrdata_o), 64'(e.t.wd));
    end else begin
      chk("port_idle_en", 64'(en_o), 64'd0);
      chk("port_idle_we", 64'(we_o), 64'd0);
    end
  end

  // Response monitor: routed read data exactly READ_LATENCY cycles after the port beat.
  always @(negedge clk) begin
    tim_t e;
    if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
      e = rsp_q.pop_front();
      chk("rsp_valid", 64'(rsp_valid), 64'd1 << e.t.id);
      chk("rsp_rddata", 64'(rsp_rddata), 64'(e.t.rd));
    end else begin
      chk("rsp_idle", 64'(rsp_valid), 64'd0);
    end
  end

  task automatic send(input int r, input logic [WW-1:0] w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic last);
    int  waited;
    bit  hs;
    waited = 0;
    v[r] = 1'b1; we[r] = w; ad[r] = a; wd[r] = d; l[r] = last;
    forever begin
      @(negedge clk);
      hs = req_ready[r] && rstn;
      @(posedge clk);
      #1;
      if (hs) break;
      waited++;
      if (waited > 40) begin
        chk("send_timeout", 64'(waited), 64'd40);
        break;
      end
    end
    v[r] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((acc_q.size() + port_q.size() + rsp_q.size()) != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 64'(acc_q.size() + port_q.size() + rsp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_en"}, 64'(en_o), 64'd0);
    chk({tag, "_we"}, 64'(we_o), 64'd0);
    chk({tag, "_addr"}, 64'(addr_o), 64'd0);
    chk({tag, "_wrdata"}, 64'(wrdata_o), 64'd0);
    chk({tag, "_rsp"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < NR; i++) begin
      v[i] = 1'b0; l[i] = 1'b0; we[i] = '0; ad[i] = '0; wd[i] = '0;
    end

    // Reset with both requesters already asking: nothing may be accepted.
    v[0] = 1'b1; l[0] = 1'b1; ad[0] = 12'h010;
    v[1] = 1'b1; l[1] = 1'b1; ad[1] = 12'h020;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("reset");
    end

    // Round robin of single-beat reads, r0 first after release.
    acc_q.push_back(mk(0, '0, 12'h010, '0, M010));
    acc_q.push_back(mk(1, '0, 12'h020, '0, M020));
    acc_q.push_back(mk(0, '0, 12'h010, '0, M010));
    acc_q.push_back(mk(1, '0, 12'h020, '0, M020));
    @(posedge clk);
    #1 rstn = 1'b1;
    fork
      begin
        send(0, '0, 12'h010, '0, 1'b1);
        send(0, '0, 12'h010, '0, 1'b1);
      end
      begin
        send(1, '0, 12'h020, '0, 1'b1);
        send(1, '0, 12'h020, '0, 1'b1);
      end
    join
    drain();

    // Burst lock with a two-cycle bubble while r1 waits.
    for (int k = 0; k < 4; k++) begin
      acc_q.push_back(mk(0, 4'hF, AW'(12'h100 + k), 32'hA000_0100 + DW'(k), '0));
    end
    acc_q.push_back(mk(1, '0, 12'h020, '0, M020));
    fork
      begin
        send(0, 4'hF, 12'h100, 32'hA000_0100, 1'b0);
        send(0, 4'hF, 12'h101, 32'hA000_0101, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send(0, 4'hF, 12'h102, 32'hA000_0102, 1'b0);
        send(0, 4'hF, 12'h103, 32'hA000_0103, 1'b1);
      end
      send(1, '0, 12'h020, '0, 1'b1);
    join
    drain();

    // Read routed to r1 only.
    acc_q.push_back(mk(1, '0, 12'h005, '0, M005));
    send(1, '0, 12'h005, '0, 1'b1);
    drain();

    // Mixed write-then-read burst; read sees the partial-byte write.
    acc_q.push_back(mk(0, 4'h3, 12'h007, 32'h1234_5678, '0));
    acc_q.push_back(mk(0, '0, 12'h007, '0, 32'hAABB_5678));
    send(0, 4'h3, 12'h007, 32'h1234_5678, 1'b0);
    send(0, '0, 12'h007, '0, 1'b1);
    drain();

    // Reset during an r1 read burst with two reads in flight; prio is 1 beforehand.
    acc_q.push_back(mk(1, '0, 12'h010, '0, M010));
    acc_q.push_back(mk(1, '0, 12'h020, '0, M020));
    send(1, '0, 12'h010, '0, 1'b0);
    send(1, '0, 12'h020, '0, 1'b0);
    rstn = 1'b0;
    rsp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    acc_q.push_back(mk(0, '0, 12'h010, '0, M010));
    acc_q.push_back(mk(1, '0, 12'h020, '0, M020));
    fork
      send(0, '0, 12'h010, '0, 1'b1);
      send(1, '0, 12'h020, '0, 1'b1);
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
